// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS HI/LO multiply/divide unit: operation codes and FSM states.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'd0,
        OpMultu = 2'd1,
        OpDiv   = 2'd2,
        OpDivu  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFixup = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mips_cpu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic                    start;
    mips_cpu_pkg::muldiv_op_t op;
    logic [WIDTH-1:0]        a;
    logic [WIDTH-1:0]        b;
    logic                    hi_write;
    logic                    lo_write;
    logic [WIDTH-1:0]        write_data;
    logic                    busy;
    logic                    done;
    logic [WIDTH-1:0]        hi;
    logic [WIDTH-1:0]        lo;

    modport master (
        output start, op, a, b, hi_write, lo_write, write_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_write, lo_write, write_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// with sign correction applied in a final FIXUP cycle.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    mips_cpu_muldiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    muldiv_state_t    r_state;
    muldiv_state_t    w_state_next;
    logic [CntW-1:0]  r_count;
    muldiv_op_t       r_op;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shf;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_add_a;
    logic [WIDTH:0]   w_add_b;
    logic             w_add_cin;
    logic [WIDTH+1:0] w_add_sum;
    logic             w_div_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else if (clk_enable) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StRun;
            StRun:   if (r_count == CntW'(1)) w_state_next = StFixup;
            StFixup: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operand magnitudes; most-negative stays as its own magnitude, which is correct unsigned.
    always_comb begin
        w_a_neg = op_is_signed(bus.op) & bus.a[WIDTH-1];
        w_b_neg = op_is_signed(bus.op) & bus.b[WIDTH-1];
        w_a_mag = w_a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        w_b_mag = w_b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
    end

    // Single shared adder: multiply adds the multiplicand, divide adds ~divisor + 1.
    assign w_is_div = op_is_div(r_op);

    always_comb begin
        w_add_a   = {1'b0, r_acc};
        w_add_b   = '0;
        w_add_cin = 1'b0;
        if (w_is_div) begin
            w_add_a   = {r_acc, r_shf[WIDTH-1]};
            w_add_b   = ~{1'b0, r_opnd};
            w_add_cin = 1'b1;
        end else if (r_shf[0]) begin
            w_add_b = {1'b0, r_opnd};
        end
    end

    assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(WIDTH + 1){1'b0}}, w_add_cin};
    assign w_div_ge  = w_add_sum[WIDTH+1];

    always_comb begin
        w_prod     = {r_acc, r_shf};
        w_prod_fix = r_neg_res ? (~w_prod + (2 * WIDTH)'(1)) : w_prod;
        if (w_is_div) begin
            // Divide-by-zero leaves the dividend in the remainder, so only the quotient needs forcing.
            w_res_lo = r_div_zero ? '1 : (r_neg_res ? (~r_shf + WIDTH'(1)) : r_shf);
            w_res_hi = r_neg_rem ? (~r_acc + WIDTH'(1)) : r_acc;
        end else begin
            w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_op       <= OpMult;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_shf      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else if (clk_enable) begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.hi_write) r_hi <= bus.write_data;
                    if (bus.lo_write) r_lo <= bus.write_data;
                    if (bus.start) begin
                        r_op       <= bus.op;
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= (bus.b == '0);
                        r_count    <= CntW'(WIDTH);
                        r_acc      <= '0;
                        if (op_is_div(bus.op)) begin
                            r_opnd <= w_b_mag;
                            r_shf  <= w_a_mag;
                        end else begin
                            r_opnd <= w_a_mag;
                            r_shf  <= w_b_mag;
                        end
                    end
                end
                StRun: begin
                    r_count <= r_count - CntW'(1);
                    if (w_is_div) begin
                        r_acc <= w_div_ge ? w_add_sum[WIDTH-1:0] : w_add_a[WIDTH-1:0];
                        r_shf <= {r_shf[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_add_sum[WIDTH:1];
                        r_shf <= {w_add_sum[0], r_shf[WIDTH-1:1]};
                    end
                end
                StFixup: begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != StIdle);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits (even, >= 4).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port: clk_enable  input  1  when low, all state holds (reset excepted).
REQ-005 SHALL have port: start  input  1  request an operation; sampled only in IDLE.
REQ-006 SHALL have port: op  input  2  operation code (muldiv_op_t).
REQ-007 SHALL have ports: a, b  input  WIDTH  operands (Rs, Rt), sampled with start.
REQ-008 SHALL have ports: hi_write, lo_write  input  1  MTHI/MTLO strobes.
REQ-009 SHALL have port: write_data  input  WIDTH  MTHI/MTLO data.
REQ-010 SHALL have port: busy  output  1  operation in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when hi/lo are updated by an operation.
REQ-012 SHALL have ports: hi, lo  output  WIDTH  HI/LO register contents.

Function
REQ-013 SHALL implement op encodings: MULT=0 (signed), MULTU=1, DIV=2 (signed), DIVU=3.
REQ-014 SHALL implement FSM states IDLE -> RUN -> FIXUP -> IDLE; all transitions occur only on enabled edges.
REQ-015 SHALL, in IDLE on an enabled edge with start=1, latch operand magnitudes (abs value for signed ops, raw for unsigned), op, and sign flags; load the step counter with WIDTH; enter RUN.
REQ-016 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per enabled RUN edge; after WIDTH steps SHALL enter FIXUP.
REQ-017 SHALL, on the FIXUP edge, write hi/lo, assert done for exactly one enabled cycle, and return to IDLE. If start is sampled at edge E0, the update occurs at edge E0+WIDTH+1 (enabled edges only).
REQ-018 SHALL assert busy in RUN and FIXUP only; busy and done are never both 1.
REQ-019 SHALL set multiply results as {hi,lo} = 2*WIDTH-bit product; for MULT the product is negated when operand signs differ.
REQ-020 SHALL set divide results as lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-021 SHALL handle divide by zero (either signedness) as lo = all-ones, hi = a as sampled.
REQ-022 SHALL handle DIV of most-negative by -1 as lo = most-negative, hi = 0, with no other flag.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL, in IDLE, write write_data to hi/lo on hi_write/lo_write (each independently), with effect visible the next cycle.
REQ-025 SHALL ignore hi_write/lo_write while busy.
REQ-026 SHALL, when start and hi_write/lo_write occur together in IDLE, apply both; the operation result overwrites hi/lo at FIXUP.
REQ-027 SHALL drive hi/lo as the previous values throughout RUN, changing only at FIXUP or via MTHI/MTLO.
REQ-028 SHALL, when clk_enable is low, hold state, counter, hi, lo, and done; latency is extended by the number of disabled cycles.

Reset
REQ-029 SHALL, on reset at any edge (regardless of clk_enable, including mid-RUN/FIXUP), set state=IDLE, busy=0, done=0, hi=0, lo=0, and counter=0; the aborted operation produces no result.
REQ-030 SHALL accept start on the first enabled edge after reset deasserts.

Structure
REQ-031 SHALL place muldiv_op_t and the FSM state enum in shared package mips_cpu_pkg; widths SHALL derive from WIDTH (counter width = $clog2(WIDTH+1)).
REQ-032 SHALL be a single module with no sub-module; one WIDTH+1-bit adder/subtractor SHALL be shared between multiply and divide steps.
REQ-033 SHALL use no behavioural '*', '/' or '%' operators; the design SHALL be fully synthesisable.

Verification (WIDTH=32)
REQ-034 SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001, done at E0+33, busy high for 33 cycles.
REQ-035 SHALL cover: MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=7 b=2 -> lo=3 hi=1.
REQ-036 SHALL cover: DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x1234; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-037 SHALL cover: start and hi_write (write_data=0xAAAA5555) issued mid-RUN are ignored, leaving the result unchanged; clk_enable low for 5 cycles mid-RUN moves done to E0+38.
REQ-038 SHALL cover: reset at E0+10 of a MULTU -> busy=0, hi=lo=0, and no done pulse; a new DIVU 100/7 gives lo=14 hi=2.
REQ-039 SHALL cover: hi_write=1 and lo_write=1 in IDLE with write_data=0x12345678 -> hi=lo=0x12345678 on the next cycle, done=0.
